if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, 32, address/instruction width.
REQ-002 SHALL have parameter DEPTH, 4, prefetch capacity (power of two, 2..16).
REQ-003 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address.
REQ-004 SHALL have ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pc_write  in  1  fetch enable (0 = hold fetch PC, issue nothing)
- branch  in  1  branch redirect
- jump  in  1  JAL/JALR redirect
- branch_target  in  XLEN  branch target
- jalr_target  in  XLEN  jump target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_resp_valid  in  1  in-order response valid, one per accepted request, always accepted
- imem_resp_data  in  XLEN  instruction word
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode consumes head
- id_inst  out  XLEN  head instruction
- id_pc  out  XLEN  head PC
- id_pc4  out  XLEN  head PC + 4
- if_flush  out  1  kill IF/ID register this cycle

Function
REQ-005 SHALL hold fetch_pc, a pending-PC FIFO (DEPTH entries: PCs of accepted, unanswered requests), and an instruction queue (DEPTH entries of {pc, inst}).
REQ-006 SHALL keep outstanding + queued <= DEPTH at all times (credit rule); a request is issued only if outstanding + queued < DEPTH.
REQ-007 SHALL use FSM states BOOT, FETCH, DRAIN; BOOT lasts exactly one cycle after reset release, then FETCH.
REQ-008 In FETCH: imem_req_valid = pc_write & credit & ~redirect; imem_req_addr = fetch_pc.
REQ-009 On handshake (valid & ready): fetch_pc += 4 (mod 2^XLEN, wraps), PC pushed to pending FIFO.
REQ-010 Once asserted, imem_req_valid and imem_req_addr SHALL stay stable until accepted, except on redirect, which withdraws the request.
REQ-011 On imem_resp_valid: pop pending PC, push {pc, imem_resp_data} into queue; id_valid rises the cycle after the response (1-cycle latency).
REQ-012 id_inst/id_pc/id_pc4 SHALL reflect the queue head; head popped when id_valid & id_ready; push and pop in the same cycle SHALL both occur, count unchanged.
REQ-013 redirect = branch | jump; jump SHALL take priority (target = jalr_target), else branch_target.
REQ-014 On redirect: fetch_pc <= target, queue emptied, if_flush = 1 (combinational, same cycle), no request issued that cycle.
REQ-015 On redirect with outstanding requests not answered in that cycle: drop_cnt <= that number, state -> DRAIN; otherwise stay in FETCH.
REQ-016 In DRAIN: no requests; each response decrements drop_cnt and is discarded (not queued); -> FETCH in the cycle after drop_cnt reaches 0.
REQ-017 Redirect during DRAIN SHALL update fetch_pc only; drop_cnt keeps counting, state remains DRAIN.
REQ-018 id_valid SHALL be 0 in BOOT, in DRAIN, and in the cycle after a redirect.

Reset
REQ-019 Asserting rst SHALL asynchronously set: state BOOT, fetch_pc = RESET_PC, queue/pending empty, drop_cnt = 0, imem_req_valid = 0, id_valid = 0, if_flush = 0, id_inst/id_pc = 0, id_pc4 = 4.
REQ-020 Reset mid-transfer SHALL abandon all outstanding requests; the memory side is reset by the same rst.

Configuration
REQ-021 With IF_PERF_CNT_EN defined: add output perf_redirect_cnt (32 bit, reset 0), +1 per redirect cycle, saturating at 32'hFFFF_FFFF, and output perf_bubble_cnt (32 bit, reset 0), +1 per cycle in FETCH/DRAIN with id_valid = 0 and id_ready = 1, saturating at 32'hFFFF_FFFF; without it, neither port nor the counters exist.

Verification
REQ-022 Reset release, req_ready = 1, response 1 cycle after each request, id_ready = 1 -> addresses 0x0, 0x4, 0x8 in consecutive cycles; id_pc 0x0 first valid 1 cycle after its response.
REQ-023 id_ready = 0, responses always returned -> exactly 4 requests issued, then imem_req_valid = 0; id_ready = 1 -> issuing resumes the following cycle.
REQ-024 branch = jump = 1 with branch_target = 0x100, jalr_target = 0x200 -> if_flush = 1, next request address 0x200, queue empty.
REQ-025 Redirect to 0x40 with 3 outstanding -> DRAIN; 3 responses discarded, none on id_*; first new request 0x40 issued the cycle after the third response.
REQ-026 fetch_pc = 0xFFFF_FFFC accepted -> next address 0x0000_0000; rst low mid-DRAIN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch front end. Issues sequential fetch requests to
//   instruction memory, remembers the PC of every accepted request, pairs
//   in-order responses with those PCs and buffers {pc, inst} for decode.
//   Branch/jump redirects flush the buffer. Responses still in flight at
//   redirect time are dropped while in the DRAIN state.
//
// Parameters
//   XLEN      address / instruction width
//   DEPTH     prefetch capacity (power of two, 2..16)
//   RESET_PC  first fetch address
//
// Ports
//   clk, rst                 rising-edge clock, async active-low reset
//   pc_write                 fetch enable (0 = issue nothing, hold PC)
//   branch, branch_target    branch redirect
//   jump, jalr_target        JAL/JALR redirect (wins over branch)
//   imem_req_*               fetch request channel (valid/ready)
//   imem_resp_*              in-order responses, one per accepted request
//   id_valid/id_ready        decode channel (valid/ready)
//   id_inst/id_pc/id_pc4     head of the instruction buffer
//   if_flush                 kill IF/ID this cycle (combinational)
//   dbg_state                current FSM state
//
// Handshake semantics (both request and decode channels): a transfer happens
// in a cycle where valid & ready are both 1. Once the request channel raises
// valid, valid and address stay stable until the transfer, unless a redirect
// withdraws the request. Responses have no ready and are always accepted.
//
// Optional feature: define IF_PERF_CNT_EN to add perf_redirect_cnt and
// perf_bubble_cnt saturating 32-bit counters.
// -----------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            branch,
  input  logic            jump,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic            if_flush,
  output logic [1:0]      dbg_state
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_redirect_cnt,
  output logic [31:0]     perf_bubble_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            req_hold_q, req_hold_d;

  // PCs of accepted requests whose responses have not arrived yet.
  logic [XLEN-1:0] pend_mem_q [DEPTH];
  logic [PW-1:0]   pend_wr_q, pend_rd_q;
  logic [CW-1:0]   pend_cnt_q;

  // Instruction buffer towards decode.
  logic [XLEN-1:0] iq_pc_q   [DEPTH];
  logic [XLEN-1:0] iq_inst_q [DEPTH];
  logic [PW-1:0]   iq_wr_q, iq_rd_q;
  logic [CW-1:0]   iq_cnt_q;

  logic            redirect, in_fetch, credit, req_hs, answered;
  logic            resp_keep, iq_pop, flush_fetch;
  logic [XLEN-1:0] target;
  logic [CW:0]     used;

  assign redirect    = branch | jump;
  assign target      = jump ? jalr_target : branch_target;
  assign in_fetch    = (state_q == ST_FETCH);
  assign flush_fetch = in_fetch & redirect;
  // Every slot is reserved at issue time, so a response always finds room.
  assign used        = {1'b0, pend_cnt_q} + {1'b0, iq_cnt_q};
  assign credit      = (used < DEPTH_V);
  // A pending request is re-presented even if pc_write drops meanwhile.
  assign imem_req_valid = in_fetch & ~redirect & ((pc_write & credit) | req_hold_q);
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs      = imem_req_valid & imem_req_ready;
  assign answered    = imem_resp_valid & (pend_cnt_q != '0);
  assign resp_keep   = in_fetch & ~redirect & answered;
  assign id_valid    = (iq_cnt_q != '0);
  assign iq_pop      = in_fetch & ~redirect & id_valid & id_ready;
  assign id_pc       = iq_pc_q[iq_rd_q];
  assign id_inst     = iq_inst_q[iq_rd_q];
  assign id_pc4      = iq_pc_q[iq_rd_q] + XLEN'(4);
  assign if_flush    = redirect & (state_q != ST_BOOT);
  assign dbg_state   = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    req_hold_d = req_hold_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (redirect) begin
          fetch_pc_d = target;
          req_hold_d = 1'b0;
          // A response arriving in the redirect cycle is already discarded.
          drop_cnt_d = pend_cnt_q - CW'(answered);
          if (drop_cnt_d != '0) state_d = ST_DRAIN;
        end else begin
          if (req_hs) fetch_pc_d = fetch_pc_q + XLEN'(4);
          req_hold_d = imem_req_valid & ~imem_req_ready;
        end
      end
      ST_DRAIN: begin
        if (redirect) fetch_pc_d = target;
        if (drop_cnt_q == '0) begin
          state_d = ST_FETCH;
        end else if (imem_resp_valid) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
          if (drop_cnt_q == CW'(1)) state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
      req_hold_q <= 1'b0;
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      pend_cnt_q <= '0;
      iq_wr_q    <= '0;
      iq_rd_q    <= '0;
      iq_cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pend_mem_q[i] <= '0;
        iq_pc_q[i]    <= '0;
        iq_inst_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
      req_hold_q <= req_hold_d;
      if (flush_fetch) begin
        pend_wr_q  <= '0;
        pend_rd_q  <= '0;
        pend_cnt_q <= '0;
        iq_wr_q    <= '0;
        iq_rd_q    <= '0;
        iq_cnt_q   <= '0;
      end else if (in_fetch) begin
        if (req_hs) begin
          pend_mem_q[pend_wr_q] <= fetch_pc_q;
          pend_wr_q             <= pend_wr_q + PW'(1);
        end
        if (resp_keep) begin
          pend_rd_q          <= pend_rd_q + PW'(1);
          iq_pc_q[iq_wr_q]   <= pend_mem_q[pend_rd_q];
          iq_inst_q[iq_wr_q] <= imem_resp_data;
          iq_wr_q            <= iq_wr_q + PW'(1);
        end
        if (iq_pop) iq_rd_q <= iq_rd_q + PW'(1);
        pend_cnt_q <= pend_cnt_q + CW'(req_hs) - CW'(resp_keep);
        iq_cnt_q   <= iq_cnt_q + CW'(resp_keep) - CW'(iq_pop);
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_redirect_q, perf_bubble_q;
  logic        bubble;

  assign bubble            = (state_q != ST_BOOT) & ~id_valid & id_ready;
  assign perf_redirect_cnt = perf_redirect_q;
  assign perf_bubble_cnt   = perf_bubble_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_redirect_q <= '0;
      perf_bubble_q   <= '0;
    end else begin
      if (if_flush && (perf_redirect_q != 32'hFFFF_FFFF)) perf_redirect_q <= perf_redirect_q + 32'd1;
      if (bubble && (perf_bubble_q != 32'hFFFF_FFFF))     perf_bubble_q   <= perf_bubble_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, pc_write, branch, jump;
  logic [XLEN-1:0] branch_target, jalr_target;
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            id_valid, id_ready;
  logic [XLEN-1:0] id_inst, id_pc, id_pc4;
  logic            if_flush;
  logic [1:0]      dbg_state;
`ifdef IF_PERF_CNT_EN
  logic [31:0]     perf_redirect_cnt, perf_bubble_cnt;
`endif

  if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .branch(branch), .jump(jump),
    .branch_target(branch_target), .jalr_target(jalr_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4), .if_flush(if_flush),
    .dbg_state(dbg_state)
`ifdef IF_PERF_CNT_EN
    , .perf_redirect_cnt(perf_redirect_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  // ---------------- reference model / scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];   // PCs decode must see, in program order
  logic [XLEN-1:0] mem_q[$];   // accepted addresses awaiting a response
  logic [XLEN-1:0] m_fetch_pc; // next address the fetcher must request
  int resp_pct;

  // one-cycle observation snapshot and model predictions
  logic            o_req_valid, o_hs, o_flush, o_id_valid, o_consume, o_redirect;
  logic [XLEN-1:0] o_req_addr, o_id_pc, o_id_inst, o_id_pc4;
  logic [XLEN-1:0] e_addr, e_head;
  logic            e_has_head;
  int              e_size;
  logic            p_stall, p_redirect;
  logic [XLEN-1:0] p_addr;

  // bijective mapping so each address has a distinct instruction word
  function automatic logic [XLEN-1:0] inst_of(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    o_req_valid = 0; o_hs = 0; o_flush = 0; o_id_valid = 0; o_consume = 0;
    o_redirect = 0; o_req_addr = '0; o_id_pc = '0; o_id_inst = '0; o_id_pc4 = '0;
    p_stall = 0; p_redirect = 0; p_addr = '0;
  endtask

  task automatic do_reset();
    rst = 0; pc_write = 0; branch = 0; jump = 0;
    branch_target = '0; jalr_target = '0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0; id_ready = 0;
    mem_q.delete(); exp_q.delete(); m_fetch_pc = 32'h0; resp_pct = 100;
    clear_obs();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // Runs one clock cycle with the inputs set by the caller: drives the
  // memory response, samples outputs, records predictions, advances the model.
  task automatic cycle();
    if (mem_q.size() > 0 && $urandom_range(0, 99) < resp_pct) begin
      imem_resp_valid = 1;
      imem_resp_data  = inst_of(mem_q.pop_front());
    end else begin
      imem_resp_valid = 0;
      imem_resp_data  = $urandom;
    end
    #1;
    p_stall = o_req_valid & ~o_hs; p_addr = o_req_addr; p_redirect = o_redirect;
    o_req_valid = imem_req_valid; o_req_addr = imem_req_addr;
    o_hs = imem_req_valid & imem_req_ready; o_flush = if_flush;
    o_id_valid = id_valid; o_id_pc = id_pc; o_id_inst = id_inst; o_id_pc4 = id_pc4;
    o_consume = id_valid & id_ready; o_redirect = branch | jump;
    e_addr = m_fetch_pc; e_size = exp_q.size(); e_has_head = (e_size > 0);
    e_head = e_has_head ? exp_q[0] : '0;
    if (o_redirect) begin
      m_fetch_pc = jump ? jalr_target : branch_target;
      exp_q.delete();
    end else begin
      if (o_consume && e_has_head) void'(exp_q.pop_front());
      if (o_hs) begin
        exp_q.push_back(m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    if (o_hs) mem_q.push_back(o_req_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0; pc_write = 1; branch = 1; jump = 1; imem_req_ready = 1; id_ready = 1;
    branch_target = 32'h100; jalr_target = 32'h200; imem_resp_valid = 1;
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %b expected 0", id_valid); end
    checks++; if (if_flush !== 1'b0) begin errors++; $display("FAIL rst_if_flush: got %b expected 0", if_flush); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc: got %h expected 0", id_pc); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL rst_id_inst: got %h expected 0", id_inst); end
    checks++; if (id_pc4 !== 32'h4) begin errors++; $display("FAIL rst_id_pc4: got %h expected 4", id_pc4); end
  endtask

  task automatic test_sequential();
    do_reset();
    pc_write = 1; imem_req_ready = 1; id_ready = 1; resp_pct = 100;
    cycle();
    checks++; if (o_req_valid !== 1'b0) begin errors++; $display("FAIL boot_req_valid: got %b expected 0", o_req_valid); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (o_req_valid !== 1'b1 || o_req_addr !== 32'(i * 4)) begin
        errors++; $display("FAIL seq_addr%0d: got valid=%b addr=%h expected valid=1 addr=%h", i, o_req_valid, o_req_addr, 32'(i * 4));
      end
      if (i == 1) begin
        checks++; if (o_id_valid !== 1'b0) begin errors++; $display("FAIL seq_early_id_valid: got %b expected 0", o_id_valid); end
      end
      if (i == 2) begin
        checks++;
        if (o_id_valid !== 1'b1 || o_id_pc !== 32'h0 || o_id_inst !== inst_of(32'h0)) begin
          errors++; $display("FAIL seq_first_id: got valid=%b pc=%h inst=%h expected 1 0 %h", o_id_valid, o_id_pc, o_id_inst, inst_of(32'h0));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int hs_cnt = 0;
    do_reset();
    pc_write = 1; imem_req_ready = 1; id_ready = 0; resp_pct = 100;
    repeat (12) begin
      cycle();
      if (o_hs) hs_cnt++;
    end
    checks++; if (hs_cnt != DEPTH) begin errors++; $display("FAIL bp_req_count: got %0d expected %0d", hs_cnt, DEPTH); end
    checks++; if (o_req_valid !== 1'b0) begin errors++; $display("FAIL bp_full_valid: got %b expected 0", o_req_valid); end
    id_ready = 1;
    cycle();
    checks++;
    if (o_req_valid !== 1'b0 || o_consume !== 1'b1 || o_id_pc !== 32'h0) begin
      errors++; $display("FAIL bp_release: got req_valid=%b consume=%b pc=%h expected 0 1 0", o_req_valid, o_consume, o_id_pc);
    end
    cycle();
    checks++;
    if (o_req_valid !== 1'b1 || o_req_addr !== 32'h10) begin
      errors++; $display("FAIL bp_resume: got valid=%b addr=%h expected 1 00000010", o_req_valid, o_req_addr);
    end
  endtask

  task automatic test_redirect_priority();
    logic seen = 0;
    do_reset();
    pc_write = 1; imem_req_ready = 1; id_ready = 0; resp_pct = 100;
    repeat (4) cycle();
    branch = 1; jump = 1; branch_target = 32'h100; jalr_target = 32'h200;
    cycle();
    checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL redir_flush: got %b expected 1", o_flush); end
    checks++; if (o_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_valid: got %b expected 0", o_req_valid); end
    branch = 0; jump = 0; id_ready = 1;
    cycle();
    checks++; if (o_id_valid !== 1'b0) begin errors++; $display("FAIL redir_id_valid_after: got %b expected 0", o_id_valid); end
    checks++;
    if (o_req_valid !== 1'b1 || o_req_addr !== 32'h200) begin
      errors++; $display("FAIL redir_target: got valid=%b addr=%h expected 1 00000200", o_req_valid, o_req_addr);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (o_consume) begin
        seen = 1;
        checks++; if (o_id_pc !== 32'h200) begin errors++; $display("FAIL redir_first_decode: got %h expected 00000200", o_id_pc); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL redir_timeout: got no decode expected one within 10 cycles"); end
  endtask

  task automatic test_drain();
    int hs_cnt = 0;
    do_reset();
    pc_write = 1; imem_req_ready = 1; id_ready = 1; resp_pct = 0;
    cycle();
    for (int i = 0; i < 10 && hs_cnt < 3; i++) begin
      cycle();
      if (o_hs) hs_cnt++;
    end
    checks++; if (hs_cnt != 3) begin errors++; $display("FAIL drain_setup: got %0d requests expected 3", hs_cnt); end
    jump = 1; jalr_target = 32'h80;
    cycle();
    checks++;
    if (o_flush !== 1'b1 || o_req_valid !== 1'b0) begin
      errors++; $display("FAIL drain_redirect: got flush=%b req_valid=%b expected 1 0", o_flush, o_req_valid);
    end
    jump = 0; branch = 1; branch_target = 32'h40;
    cycle();
    checks++;
    if (o_req_valid !== 1'b0 || o_id_valid !== 1'b0) begin
      errors++; $display("FAIL drain_second_redirect: got req_valid=%b id_valid=%b expected 0 0", o_req_valid, o_id_valid);
    end
    branch = 0; resp_pct = 100;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (o_req_valid !== 1'b0 || o_id_valid !== 1'b0 || imem_resp_valid !== 1'b1) begin
        errors++; $display("FAIL drain_discard%0d: got req_valid=%b id_valid=%b resp=%b expected 0 0 1", i, o_req_valid, o_id_valid, imem_resp_valid);
      end
    end
    cycle();
    checks++;
    if (o_req_valid !== 1'b1 || o_req_addr !== 32'h40) begin
      errors++; $display("FAIL drain_resume: got valid=%b addr=%h expected 1 00000040", o_req_valid, o_req_addr);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    pc_write = 1; imem_req_ready = 1; id_ready = 1; resp_pct = 100;
    cycle();
    jump = 1; jalr_target = 32'hFFFF_FFFC;
    cycle();
    jump = 0;
    cycle();
    checks++;
    if (o_hs !== 1'b1 || o_req_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top: got hs=%b addr=%h expected 1 fffffffc", o_hs, o_req_addr);
    end
    cycle();
    checks++;
    if (o_req_valid !== 1'b1 || o_req_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_zero: got valid=%b addr=%h expected 1 00000000", o_req_valid, o_req_addr);
    end
    resp_pct = 0;
    cycle(); cycle();
    branch = 1; branch_target = 32'h300;
    cycle();
    cycle();
    checks++; if (o_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain_idle: got %b expected 0", o_req_valid); end
    rst = 0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || if_flush !== 1'b0 ||
        id_pc !== 32'h0 || id_inst !== 32'h0 || id_pc4 !== 32'h4) begin
      errors++; $display("FAIL drain_async_reset: got req_valid=%b id_valid=%b flush=%b pc=%h inst=%h pc4=%h expected 0 0 0 0 0 4",
                         imem_req_valid, id_valid, if_flush, id_pc, id_inst, id_pc4);
    end
    branch = 0;
  endtask

  task automatic test_random();
    int consumed = 0;
    int r;
    do_reset();
    resp_pct = 60;
    cycle();
    for (int n = 0; n < 3000; n++) begin
      pc_write       = ($urandom_range(0, 9) < 8);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      id_ready       = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 99);
      branch = (r < 4);
      jump   = (r >= 2 && r < 6);
      branch_target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : (32'($urandom_range(0, 1023)) << 2);
      jalr_target   = 32'($urandom_range(0, 1023)) << 2;
      cycle();
      if (o_consume) consumed++;
      if (o_req_valid) begin
        checks++;
        if (o_req_addr !== e_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %h expected %h", n, o_req_addr, e_addr); end
        checks++;
        if (e_size >= DEPTH) begin errors++; $display("FAIL rnd_credit@%0d: got request with %0d in flight expected fewer than %0d", n, e_size, DEPTH); end
      end
      if (o_id_valid) begin
        checks++;
        if (!e_has_head || o_id_pc !== e_head || o_id_inst !== inst_of(e_head) || o_id_pc4 !== e_head + 32'd4) begin
          errors++; $display("FAIL rnd_head@%0d: got pc=%h inst=%h pc4=%h expected have=%b pc=%h inst=%h", n, o_id_pc, o_id_inst, o_id_pc4, e_has_head, e_head, inst_of(e_head));
        end
      end
      checks++;
      if (o_flush !== o_redirect) begin errors++; $display("FAIL rnd_flush@%0d: got %b expected %b", n, o_flush, o_redirect); end
      if (p_redirect) begin
        checks++;
        if (o_id_valid !== 1'b0) begin errors++; $display("FAIL rnd_post_redirect@%0d: got id_valid=%b expected 0", n, o_id_valid); end
      end
      if (p_stall && !o_redirect) begin
        checks++;
        if (o_req_valid !== 1'b1 || o_req_addr !== p_addr) begin
          errors++; $display("FAIL rnd_stable@%0d: got valid=%b addr=%h expected 1 %h", n, o_req_valid, o_req_addr, p_addr);
        end
      end
    end
    checks++;
    if (consumed < 100) begin errors++; $display("FAIL rnd_progress: got %0d decoded expected at least 100", consumed); end
  endtask

  // ---------------- sequence / final report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_priority();
    test_drain();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before 2000000 ns");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
